cpu_control_unit: RTL and testbench

//  Microsequencer for the down-sampling CPU datapath: fetch / decode / execute / writeback / PC-increment.

---
 rtl/cpu_ctrl_pkg.sv | 72 +++++++
 rtl/onehot_dec.sv | 24 ++
 rtl/cpu_control_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the CPU microsequencer: opcode values, ALU codes,
// FSM state encoding, instruction field offsets and the registered strobe
// bundle. Instruction layout (20 bits):
//   op[19:16] rd[15:11] rs[10:7] shamt[6:3] rsvd[2:0]
package cpu_ctrl_pkg;

    // Instruction field offsets and widths
    localparam int OP_LSB = 16;
    localparam int OP_W   = 4;
    localparam int RD_LSB = 11;
    localparam int RD_W   = 5;
    localparam int RS_LSB = 7;
    localparam int RS_W   = 4;
    localparam int SH_LSB = 3;
    localparam int SH_W   = 4;

    // Opcodes; 0..7 are ALU ops whose low bits go straight to the ALU
    localparam logic [OP_W-1:0] OP_LOAD  = 4'd8;
    localparam logic [OP_W-1:0] OP_STORE = 4'd9;
    localparam logic [OP_W-1:0] OP_JMP   = 4'd10;
    localparam logic [OP_W-1:0] OP_JMPZ  = 4'd11;
    localparam logic [OP_W-1:0] OP_MOV   = 4'd12;
    localparam logic [OP_W-1:0] OP_HALT  = 4'd15;

    // ALU codes
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEMX   = 3'd4,
        S_WB     = 3'd5,
        S_PCINC  = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    // Registered single-bit strobes plus ALU controls
    typedef struct packed {
        logic       fetch;
        logic       pc1;
        logic       decode;
        logic       ins_con;
        logic       mem_read;
        logic       mem_write;
        logic       read_ac;
        logic       busy;
        logic       halted;
        logic       illegal;
        logic [2:0] op;
        logic [3:0] shift;
    } ctrl_out_t;

    // ALU ops, STORE and MOV put a register on the B bus
    function automatic logic op_uses_rs(input logic [OP_W-1:0] op);
        return !op[3] || (op == OP_STORE) || (op == OP_MOV);
    endfunction

    // ALU ops, LOAD and MOV write a register on the C bus
    function automatic logic op_uses_rd(input logic [OP_W-1:0] op);
        return !op[3] || (op == OP_LOAD) || (op == OP_MOV);
    endfunction

    // 13 and 14 are unassigned
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return !((op == 4'd13) || (op == 4'd14));
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// onehot_dec
// Binary index to N-bit one-hot. An index at or beyond N yields all zeros and
// raises out_of_range.
//   idx          in  IW  binary index
//   onehot       out N   one-hot (or zero) select
//   out_of_range out 1   idx >= N
module onehot_dec #(
    parameter int N  = 15,
    parameter int IW = 4
) (
    input  logic [IW-1:0] idx,
    output logic [N-1:0]  onehot,
    output logic          out_of_range
);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            onehot[i] = (32'(idx) == i);
        end
    end

    assign out_of_range = (32'(idx) >= N);

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit
// Microsequencer for the down-sampling CPU: fetch / decode / execute /
// writeback / PC-increment. All outputs are registered: the output logic
// decodes the *next* state and the register makes them line up with it.
//   clk, rst         clock, async active-high reset
//   start            leave IDLE/HALT (sampled only there)
//   IR_in, z_flag    instruction word (valid in DECODE), ALU zero flag
//   fetch, PC1, Decode, Ins_Con, Mem_Read, Mem_Write   sequencing strobes
//   Read_AC, Read_RL, Write_RL, Op, shift              datapath selects
//   busy, halted, illegal                              status
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int INS_W   = 20,
    parameter int N_RD    = 15,
    parameter int N_WR    = 18,
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [INS_W-1:0] IR_in,
    input  logic             z_flag,
    output logic             fetch,
    output logic             PC1,
    output logic             Decode,
    output logic             Ins_Con,
    output logic             Mem_Read,
    output logic             Mem_Write,
    output logic             Read_AC,
    output logic [N_RD-1:0]  Read_RL,
    output logic [N_WR-1:0]  Write_RL,
    output logic [2:0]       Op,
    output logic [3:0]       shift,
    output logic             busy,
    output logic             halted,
    output logic             illegal
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [INS_W-1:0] ir_q;
    ctrl_out_t       out_q, out_d;
    logic [N_RD-1:0] read_rl_q, read_rl_d;
    logic [N_WR-1:0] write_rl_q, write_rl_d;
    logic            rd_en, wr_en;

    // In DECODE the latch is not loaded yet, so look through to IR_in
    logic [INS_W-1:0] ir_cur;
    logic [OP_W-1:0]  op_c;
    logic [RD_W-1:0]  rd_c;
    logic [RS_W-1:0]  rs_c;
    logic [SH_W-1:0]  sh_c;
    logic             unused_rsvd;

    assign ir_cur      = (state_q == S_DECODE) ? IR_in : ir_q;
    assign op_c        = ir_cur[OP_LSB +: OP_W];
    assign rd_c        = ir_cur[RD_LSB +: RD_W];
    assign rs_c        = ir_cur[RS_LSB +: RS_W];
    assign sh_c        = ir_cur[SH_LSB +: SH_W];
    assign unused_rsvd = ^ir_cur[2:0];

    logic [N_RD-1:0] rs_hot;
    logic [N_WR-1:0] rd_hot;
    logic            rs_oor, rd_oor, bad_ins;

    onehot_dec #(.N(N_RD), .IW(RS_W)) u_rd_dec (
        .idx          (rs_c),
        .onehot       (rs_hot),
        .out_of_range (rs_oor)
    );

    onehot_dec #(.N(N_WR), .IW(RD_W)) u_wr_dec (
        .idx          (rd_c),
        .onehot       (rd_hot),
        .out_of_range (rd_oor)
    );

    // Only operand fields the opcode actually uses can make it illegal
    assign bad_ins = !op_legal(op_c)
                   || (op_uses_rs(op_c) && rs_oor)
                   || (op_uses_rd(op_c) && rd_oor);

    assign read_rl_d  = rd_en ? rs_hot : '0;
    assign write_rl_d = wr_en ? rd_hot : '0;

    // State, counter, IR latch and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ir_q       <= '0;
            out_q      <= '0;
            read_rl_q  <= '0;
            write_rl_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            read_rl_q  <= read_rl_d;
            write_rl_q <= write_rl_d;
            if (state_q == S_DECODE) ir_q <= IR_in;
        end
    end

    // Next state and memory-latency counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    cnt_d   = LAT_M1;
                end
            end
            S_FETCH: begin
                if (cnt_q == '0) state_d = S_DECODE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DECODE: begin
                if (op_c == OP_HALT) begin
                    state_d = S_HALT;
                end else if (op_c == OP_LOAD) begin
                    state_d = S_MEMX;
                    cnt_d   = LAT_M1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!op_c[3] || op_c == OP_MOV) begin
                    state_d = S_WB;
                end else if (op_c == OP_STORE) begin
                    state_d = S_MEMX;
                    cnt_d   = '0;   // write lasts exactly one cycle
                end else if (op_c == OP_JMP || (op_c == OP_JMPZ && out_q.ins_con)) begin
                    state_d = S_FETCH;
                    cnt_d   = LAT_M1;
                end else begin
                    state_d = S_PCINC;
                end
            end
            S_MEMX: begin
                if (cnt_q != '0)           cnt_d   = cnt_q - 1'b1;
                else if (op_c == OP_LOAD)  state_d = S_WB;
                else                       state_d = S_PCINC;
            end
            S_WB:    state_d = S_PCINC;
            S_PCINC: begin
                state_d = S_FETCH;
                cnt_d   = LAT_M1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs for the state being entered
    always_comb begin
        out_d      = '0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        out_d.busy = !(state_d == S_IDLE || state_d == S_HALT);
        case (state_d)
            S_FETCH: begin
                out_d.fetch    = 1'b1;
                out_d.mem_read = 1'b1;
            end
            S_DECODE: out_d.decode = 1'b1;
            S_EXEC: begin
                if (!op_c[3]) begin
                    out_d.read_ac = 1'b1;
                    out_d.op      = op_c[2:0];
                    out_d.shift   = sh_c;
                    rd_en         = 1'b1;
                end else if (op_c == OP_STORE || op_c == OP_MOV) begin
                    rd_en = 1'b1;   // Op stays ALU_PASS
                end else if (op_c == OP_JMP) begin
                    out_d.ins_con = 1'b1;
                end else if (op_c == OP_JMPZ) begin
                    // The flag is taken on the edge into EXEC so that the
                    // registered Ins_Con is already valid during EXEC; the
                    // same register then steers EXEC's exit.
                    out_d.ins_con = z_flag;
                end
            end
            S_MEMX: begin
                if (op_c == OP_LOAD) begin
                    out_d.mem_read = 1'b1;
                end else begin
                    out_d.mem_write = 1'b1;
                    rd_en           = 1'b1;   // keep store data on the B bus
                end
            end
            S_WB:    wr_en        = 1'b1;
            S_PCINC: out_d.pc1    = 1'b1;
            S_HALT:  out_d.halted = 1'b1;
            default: ;
        endcase
        // One pulse in the first cycle after DECODE (EXEC, or MEMX for LOAD)
        out_d.illegal = (state_q == S_DECODE) && (op_c != OP_HALT) && bad_ins;
    end

    assign fetch     = out_q.fetch;
    assign PC1       = out_q.pc1;
    assign Decode    = out_q.decode;
    assign Ins_Con   = out_q.ins_con;
    assign Mem_Read  = out_q.mem_read;
    assign Mem_Write = out_q.mem_write;
    assign Read_AC   = out_q.read_ac;
    assign busy      = out_q.busy;
    assign halted    = out_q.halted;
    assign illegal   = out_q.illegal;
    assign Op        = out_q.op;
    assign shift     = out_q.shift;
    assign Read_RL   = read_rl_q;
    assign Write_RL  = write_rl_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit
// Scoreboard bench: each instruction pushes its expected per-cycle output
// snapshots, then the DUT is stepped and each cycle is popped and compared.
module tb_cpu_control_unit;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst, start, z_flag;
    logic [19:0] IR_in;
    logic        fetch, PC1, Decode, Ins_Con, Mem_Read, Mem_Write, Read_AC;
    logic [14:0] Read_RL;
    logic [17:0] Write_RL;
    logic [2:0]  Op;
    logic [3:0]  shift;
    logic        busy, halted, illegal;

    always #5 clk = ~clk;

    cpu_control_unit #(.INS_W(20), .N_RD(15), .N_WR(18), .MEM_LAT(L)) dut (
        .clk(clk), .rst(rst), .start(start), .IR_in(IR_in), .z_flag(z_flag),
        .fetch(fetch), .PC1(PC1), .Decode(Decode), .Ins_Con(Ins_Con),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Read_AC(Read_AC),
        .Read_RL(Read_RL), .Write_RL(Write_RL), .Op(Op), .shift(shift),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    typedef struct packed {
        logic fetch, pc1, decode, ins_con, mem_read, mem_write, read_ac;
        logic busy, halted, illegal;
        logic [2:0]  op;
        logic [3:0]  shift;
        logic [14:0] read_rl;
        logic [17:0] write_rl;
    } snap_t;

    snap_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic snap_t cur();
        snap_t s;
        s.fetch = fetch;   s.pc1 = PC1;             s.decode = Decode;
        s.ins_con = Ins_Con; s.mem_read = Mem_Read; s.mem_write = Mem_Write;
        s.read_ac = Read_AC; s.busy = busy;         s.halted = halted;
        s.illegal = illegal; s.op = Op;             s.shift = shift;
        s.read_rl = Read_RL; s.write_rl = Write_RL;
        return s;
    endfunction

    function automatic logic [14:0] hot15(input int i);
        return (i < 15) ? (15'(1) << i) : 15'(0);
    endfunction

    function automatic logic [17:0] hot18(input int i);
        return (i < 18) ? (18'(1) << i) : 18'(0);
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction from its first FETCH
    task automatic push_instr(input int op, input int rd, input int rs, input int sh, input logic z);
        snap_t base, s;
        logic  ill, urs, urd;
        urs  = (op <= 7) || (op == 9) || (op == 12);
        urd  = (op <= 8) || (op == 12);
        ill  = (op == 13) || (op == 14) || (urs && rs >= 15) || (urd && rd >= 18);
        base = '0;
        base.busy = 1'b1;
        for (int i = 0; i < L; i++) begin
            s = base; s.fetch = 1'b1; s.mem_read = 1'b1; exp_q.push_back(s);
        end
        s = base; s.decode = 1'b1; exp_q.push_back(s);
        if (op == 15) begin
            s = '0; s.halted = 1'b1; exp_q.push_back(s);
            return;
        end
        s = base; s.illegal = ill;
        if (op <= 7) begin
            s.read_ac = 1'b1; s.read_rl = hot15(rs); s.op = 3'(op); s.shift = 4'(sh);
            exp_q.push_back(s);
            s = base; s.write_rl = hot18(rd); exp_q.push_back(s);
        end else if (op == 8) begin
            for (int i = 0; i < L; i++) begin
                s.mem_read = 1'b1; exp_q.push_back(s); s = base;
            end
            s = base; s.write_rl = hot18(rd); exp_q.push_back(s);
        end else if (op == 9) begin
            s.read_rl = hot15(rs); exp_q.push_back(s);
            s = base; s.mem_write = 1'b1; s.read_rl = hot15(rs); exp_q.push_back(s);
        end else if (op == 10) begin
            s.ins_con = 1'b1; exp_q.push_back(s);
            return;
        end else if (op == 11) begin
            s.ins_con = z; exp_q.push_back(s);
            if (z) return;
        end else if (op == 12) begin
            s.read_rl = hot15(rs); exp_q.push_back(s);
            s = base; s.write_rl = hot18(rd); exp_q.push_back(s);
        end else begin
            exp_q.push_back(s);
        end
        s = base; s.pc1 = 1'b1; exp_q.push_back(s);
    endtask

    // Drive one instruction (entered from IDLE/HALT or straight after the
    // previous one) and compare at most max_cyc cycles of it.
    task automatic run_instr(input string nm, input int op, input int rd, input int rs,
                             input int sh, input logic z, input int max_cyc);
        snap_t e;
        int    n = 0;
        IR_in  = {op[3:0], rd[4:0], rs[3:0], sh[3:0], 3'b000};
        z_flag = z;
        start  = 1'b1;
        push_instr(op, rd, rs, sh, z);
        while (exp_q.size() > 0 && n < max_cyc) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            chk($sformatf("%s[%0d]", nm, n), 64'(cur()), 64'(e));
            n++;
        end
        exp_q.delete();
    endtask

    initial begin
        snap_t hs;
        rst = 1'b1; start = 1'b0; IR_in = '0; z_flag = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", 64'(cur()), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", 64'(cur()), 64'(0));

        run_instr("add_rs1_rd0", 1, 0, 1, 2, 1'b0, 100);

        // Reset while the ADD sits in WB: selects must drop immediately
        run_instr("add_rd3", 1, 3, 2, 0, 1'b0, L + 3);
        rst = 1'b1;
        #1;
        chk("rst_wb_write_rl", 64'(Write_RL), 64'(0));
        chk("rst_wb_busy", 64'(busy), 64'(0));
        chk("rst_wb_all", 64'(cur()), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", 64'(cur()), 64'(0));

        run_instr("pass_r0", 0, 0, 0, 0, 1'b0, 100);
        run_instr("alu_op2", 2, 17, 14, 15, 1'b0, 100);
        run_instr("alu_op7", 7, 9, 6, 5, 1'b1, 100);
        run_instr("load_rd17", 8, 17, 0, 0, 1'b0, 100);
        run_instr("store_rs4", 9, 0, 4, 0, 1'b0, 100);
        run_instr("mov", 12, 5, 3, 0, 1'b0, 100);
        run_instr("jmp", 10, 0, 0, 0, 1'b0, 100);
        run_instr("jmpz_taken", 11, 0, 0, 0, 1'b1, 100);
        run_instr("jmpz_not", 11, 0, 0, 0, 1'b0, 100);
        run_instr("ill_rs15", 3, 2, 15, 1, 1'b0, 100);
        run_instr("ill_rd18", 12, 18, 1, 0, 1'b0, 100);
        run_instr("ill_op13", 13, 0, 0, 0, 1'b0, 100);
        run_instr("ill_op14", 14, 1, 1, 0, 1'b0, 100);
        run_instr("halt", 15, 0, 0, 0, 1'b0, 100);

        hs = '0; hs.halted = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(hs);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("halt_hold[%0d]", i), 64'(cur()), 64'(exp_q.pop_front()));
        end

        run_instr("add_after_halt", 1, 4, 5, 3, 1'b0, 100);
        for (int k = 0; k < 6; k++) begin
            int rop;
            rop = $urandom_range(0, 14);
            run_instr($sformatf("rnd%0d_op%0d", k, rop), rop, $urandom_range(0, 19),
                      $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)), 100);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
        $onehot0({fetch, Decode, PC1, Ins_Con, Mem_Write}))
        else $error("strobe exclusivity violated");
    a_read_hot: assert property (@(posedge clk) disable iff (rst) $onehot0(Read_RL))
        else $error("Read_RL not one-hot");
    a_write_hot: assert property (@(posedge clk) disable iff (rst) $onehot0(Write_RL))
        else $error("Write_RL not one-hot");

endmodule
